// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory bus arbiter
// Purpose: FSM state encoding, client identifiers and the timeout fill word.
// Ports: none (package).
package mem_arb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } arb_state_e;

  typedef logic client_t;

  localparam client_t CLI_I = 1'b0;
  localparam client_t CLI_D = 1'b1;

  // Returned on read_data when an access is aborted by the timeout.
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arb_timer.sv
// rtl/mem_arb_timer.sv - access watchdog counter for the memory bus arbiter
// Purpose: counts cycles spent in ACCESS; flags the last allowed cycle.
// Ports:
//   clk_i     in  1  clock
//   rst_ni    in  1  asynchronous active-low reset
//   run_i     in  1  arbiter is in ACCESS; low clears the count
//   expire_o  out 1  this is the TIMEOUT_CYCLES-th ACCESS cycle
module mem_arb_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count is zero in IDLE, so it is already cleared on entry to ACCESS.
  assign cnt_d    = run_i ? cnt_q + CNT_W'(1) : '0;
  assign expire_o = run_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-client (ICache/DCache) single-word memory bus arbiter
// Purpose: round-robin grant of one cache at a time to unified memory, one-cycle
//   acks, ICache invalidate broadcast on every completed DCache write.
// Optional feature macro: MEM_ARB_TIMEOUT_EN (abort accesses after TIMEOUT_CYCLES).
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   i_req, i_address                  ICache request
//   i_ack, i_read_data                ICache completion pulse and read data
//   i_inv_valid, i_inv_address        ICache invalidate pulse and word address
//   d_req, d_address, d_write_data,
//   d_write_enable                    DCache request
//   d_ack, d_read_data                DCache completion pulse and read data
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata, mem_ready   memory access port
//   bus_error                         timeout abort pulse
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_address,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_read_data,
  output logic              i_inv_valid,
  output logic [ADDR_W-1:0] i_inv_address,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_write_data,
  input  logic              d_write_enable,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_read_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              bus_error
);

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  arb_state_e        state_q, state_d;
  client_t           last_q, last_d;
  client_t           cli_q, cli_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] i_rd_q, i_rd_d;
  logic [DATA_W-1:0] d_rd_q, d_rd_d;
  logic              inv_q, inv_d;
  logic [ADDR_W-1:0] inv_addr_q, inv_addr_d;
  logic              berr_q, berr_d;
  logic              expire;
  logic              i_elig, d_elig;
  client_t           grant;

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .run_i   (state_q == ST_ACCESS),
    .expire_o(expire)
  );
`else
  assign expire = 1'b0;
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_unused
  end
`endif

  // A client whose ack is high this cycle is still holding its old request.
  assign i_elig = i_req && !i_ack_q;
  assign d_elig = d_req && !d_ack_q;
  assign grant  = (i_elig && d_elig) ? ((last_q == CLI_I) ? CLI_D : CLI_I)
                                     : (d_elig ? CLI_D : CLI_I);

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cli_d      = cli_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    i_rd_d     = i_rd_q;
    d_rd_d     = d_rd_q;
    inv_addr_d = inv_addr_q;
    i_ack_d    = 1'b0;
    d_ack_d    = 1'b0;
    inv_d      = 1'b0;
    berr_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_elig || d_elig) begin
          state_d = ST_ACCESS;
          last_d  = grant;
          cli_d   = grant;
          if (grant == CLI_D) begin
            addr_d  = d_address & WORD_MASK;
            wdata_d = d_write_data;
            we_d    = d_write_enable;
          end else begin
            addr_d  = i_address & WORD_MASK;
            wdata_d = '0;
            we_d    = 1'b0;
          end
        end
      end
      ST_ACCESS: begin
        if (mem_ready) begin
          state_d = ST_IDLE;
          if (cli_q == CLI_D) begin
            d_ack_d = 1'b1;
            if (we_q) begin
              inv_d      = 1'b1;
              inv_addr_d = addr_q;
            end else begin
              d_rd_d = mem_rdata;
            end
          end else begin
            i_ack_d = 1'b1;
            i_rd_d  = mem_rdata;
          end
        end else if (expire) begin
          state_d = ST_IDLE;
          berr_d  = 1'b1;
          if (cli_q == CLI_D) begin
            d_ack_d = 1'b1;
            d_rd_d  = DATA_W'(TIMEOUT_DATA);
          end else begin
            i_ack_d = 1'b1;
            i_rd_d  = DATA_W'(TIMEOUT_DATA);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      last_q     <= CLI_I;
      cli_q      <= CLI_I;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      i_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
      i_rd_q     <= '0;
      d_rd_q     <= '0;
      inv_q      <= 1'b0;
      inv_addr_q <= '0;
      berr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cli_q      <= cli_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      i_ack_q    <= i_ack_d;
      d_ack_q    <= d_ack_d;
      i_rd_q     <= i_rd_d;
      d_rd_q     <= d_rd_d;
      inv_q      <= inv_d;
      inv_addr_q <= inv_addr_d;
      berr_q     <= berr_d;
    end
  end

  // mem_en decodes the state register so an async reset drops it at once.
  assign mem_en        = (state_q == ST_ACCESS);
  assign mem_we        = we_q && mem_en;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign i_ack         = i_ack_q;
  assign d_ack         = d_ack_q;
  assign i_read_data   = i_rd_q;
  assign d_read_data   = d_rd_q;
  assign i_inv_valid   = inv_q;
  assign i_inv_address = inv_addr_q;
  assign bus_error     = berr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_req, d_req, d_write_enable, mem_ready;
  logic [AW-1:0] i_address, d_address;
  logic [DW-1:0] d_write_data, mem_rdata;
  logic          i_ack, d_ack, i_inv_valid, mem_en, mem_we, bus_error;
  logic [DW-1:0] i_read_data, d_read_data, mem_wdata;
  logic [AW-1:0] i_inv_address, mem_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_address(i_address), .i_ack(i_ack), .i_read_data(i_read_data),
    .i_inv_valid(i_inv_valid), .i_inv_address(i_inv_address),
    .d_req(d_req), .d_address(d_address), .d_write_data(d_write_data),
    .d_write_enable(d_write_enable), .d_ack(d_ack), .d_read_data(d_read_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .bus_error(bus_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bounded wait for an access to start, sampled on falling edges.
  task automatic wait_en(input string tag);
    int n = 0;
    while (mem_en !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'b0, mem_en}, 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; i_req = 0; d_req = 0; d_write_enable = 0; mem_ready = 0;
    i_address = '0; d_address = '0; d_write_data = '0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {25'b0, i_ack, d_ack, i_inv_valid, mem_en, mem_we, bus_error, 1'b0}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_i_rdata", i_read_data, 32'd0);
    reset_n = 1'b1;

    // 1: ICache read, memory answers after two ACCESS cycles
    @(negedge clk);
    i_req = 1; i_address = 32'h0000_0047;
    @(negedge clk);
    chk("t1_en", {31'b0, mem_en}, 32'd1);
    chk("t1_addr", mem_addr, 32'h0000_0044);
    chk("t1_we", {31'b0, mem_we}, 32'd0);
    @(negedge clk);
    chk("t1_en_hold", {31'b0, mem_en}, 32'd1);
    mem_ready = 1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_ready = 0;
    chk("t1_ack", {30'b0, i_ack, d_ack}, 32'd2);
    chk("t1_rdata", i_read_data, 32'h1234_5678);
    chk("t1_en_drop", {31'b0, mem_en}, 32'd0);
    i_req = 0;
    @(negedge clk);
    chk("t1_ack_width", {31'b0, i_ack}, 32'd0);
    chk("t1_rdata_hold", i_read_data, 32'h1234_5678);

    // 2: DCache write with invalidate broadcast
    d_req = 1; d_address = 32'h0000_0106; d_write_data = 32'hCAFE_F00D; d_write_enable = 1;
    @(negedge clk);
    chk("t2_addr", mem_addr, 32'h0000_0104);
    chk("t2_we", {30'b0, mem_en, mem_we}, 32'd3);
    chk("t2_wdata", mem_wdata, 32'hCAFE_F00D);
    mem_ready = 1; mem_rdata = 32'hAAAA_5555;
    @(negedge clk);
    mem_ready = 0;
    chk("t2_ack_inv", {29'b0, d_ack, i_inv_valid, i_ack}, 32'd6);
    chk("t2_inv_addr", i_inv_address, 32'h0000_0104);
    chk("t2_d_rdata_kept", d_read_data, 32'd0);
    d_req = 0; d_write_enable = 0;
    @(negedge clk);
    chk("t2_pulse_width", {30'b0, d_ack, i_inv_valid}, 32'd0);

    // 6: stray mem_ready in IDLE, then a normal DCache read
    mem_ready = 1; mem_rdata = 32'h5555_0000;
    @(negedge clk);
    mem_ready = 0;
    chk("t6_stray", {29'b0, mem_en, i_ack, d_ack}, 32'd0);
    chk("t6_d_rdata", d_read_data, 32'd0);
    d_req = 1; d_address = 32'h0000_0203;
    @(negedge clk);
    chk("t6_addr", mem_addr, 32'h0000_0200);
    chk("t6_we", {30'b0, mem_en, mem_we}, 32'd2);
    mem_ready = 1; mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    mem_ready = 0;
    chk("t6_ack", {30'b0, d_ack, i_inv_valid}, 32'd2);
    chk("t6_rdata", d_read_data, 32'h0BAD_F00D);
    d_req = 0;
    @(negedge clk);

    // 5: timeout abort, or an indefinite wait without the feature
    d_req = 1; d_address = 32'h0000_0300; d_write_enable = 1; d_write_data = 32'h1111_2222;
    @(negedge clk);
`ifdef MEM_ARB_TIMEOUT_EN
    for (int k = 2; k <= TMO; k++) @(negedge clk);
    chk("t5_en_last", {31'b0, mem_en}, 32'd1);
    @(negedge clk);
    chk("t5_abort", {28'b0, mem_en, d_ack, bus_error, i_inv_valid}, 32'd6);
    chk("t5_rdata", d_read_data, 32'hDEAD_BEEF);
    d_req = 0; d_write_enable = 0;
    @(negedge clk);
    chk("t5_berr_width", {31'b0, bus_error}, 32'd0);
`else
    repeat (3 * TMO) @(negedge clk);
    chk("t5_wait", {29'b0, mem_en, d_ack, bus_error}, 32'd4);
    mem_ready = 1;
    @(negedge clk);
    mem_ready = 0;
    chk("t5_late_ack", {29'b0, d_ack, i_inv_valid, bus_error}, 32'd6);
    d_req = 0; d_write_enable = 0;
    @(negedge clk);
`endif

    // 4: reset during a DCache access, then 3: continuous tie from reset
    d_req = 1; d_address = 32'h0000_0080;
    @(negedge clk);
    chk("t4_en", {31'b0, mem_en}, 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    i_req = 1; i_address = 32'h0000_1000; d_address = 32'h0000_2000;
    #1;
    chk("t4_async_en", {31'b0, mem_en}, 32'd0);
    @(negedge clk);
    chk("t4_no_ack", {30'b0, i_ack, d_ack}, 32'd0);
    reset_n = 1'b1;

    for (int g = 0; g < 4; g++) begin
      logic exp_d;
      exp_d = (g % 2 == 0);
      wait_en($sformatf("t3_en%0d", g));
      chk($sformatf("t3_addr%0d", g), mem_addr, exp_d ? 32'h0000_2000 : 32'h0000_1000);
      mem_ready = 1; mem_rdata = 32'h100 + g;
      @(negedge clk);
      mem_ready = 0;
      chk($sformatf("t3_ack%0d", g), {30'b0, i_ack, d_ack}, exp_d ? 32'd1 : 32'd2);
      chk($sformatf("t3_rdata%0d", g), exp_d ? d_read_data : i_read_data, 32'h100 + g);
      if (g == 3) begin
        i_req = 0; d_req = 0;
      end
      @(negedge clk);
      chk($sformatf("t3_width%0d", g), {30'b0, i_ack, d_ack}, 32'd0);
    end
    chk("t3_idle_end", {31'b0, mem_en}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
